// File: rtl/multiport_reg_file_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multiport integer register file.
//   XLEN_DEFAULT / NREGS_DEFAULT : default data width and register count
//   reg_addr_t                   : architectural register index (5 bits)
//   xlen_t                       : one register's worth of data
//   REG_*                        : ABI register index constants
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [4:0]              reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd1;
  localparam reg_addr_t REG_SP   = 5'd2;
  localparam reg_addr_t REG_HP   = 5'd3;
  localparam reg_addr_t REG_RC   = 5'd4;
  localparam reg_addr_t REG_T0   = 5'd5;
  localparam reg_addr_t REG_S0   = 5'd8;
  localparam reg_addr_t REG_A0   = 5'd10;
  localparam reg_addr_t REG_T6   = 5'd31;

endpackage

// File: rtl/multiport_reg_file_read_port.sv
// ----------------------------------------------------------------------------
// reg_read_port
// One combinational read port of the register file: selects the stored value,
// overrides it with same-cycle write data when bypass is enabled, and masks
// the busy flag for a forwarded or zero-register read.
//   i_bypass_en : 0 suppresses forwarding (held low while in reset)
//   i_raddr     : register index to read
//   i_regs      : full storage array
//   i_pending   : per-register outstanding-producer bits
//   i_we/i_waddr/i_wdata : packed write ports seen this cycle
//   o_rdata     : read data
//   o_rbusy     : 1 = register has an outstanding producer not being forwarded
// ----------------------------------------------------------------------------
module reg_read_port #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int NWRITE   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                         i_bypass_en,
  input  logic [AW-1:0]                i_raddr,
  input  logic [NREGS-1:0][XLEN-1:0]   i_regs,
  input  logic [NREGS-1:0]             i_pending,
  input  logic [NWRITE-1:0]            i_we,
  input  logic [NWRITE*AW-1:0]         i_waddr,
  input  logic [NWRITE*XLEN-1:0]       i_wdata,
  output logic [XLEN-1:0]              o_rdata,
  output logic                         o_rbusy
);

  logic w_hit;

  always_comb begin
    w_hit   = 1'b0;
    o_rdata = i_regs[i_raddr];
    o_rbusy = i_pending[i_raddr];
    if (BYPASS && i_bypass_en) begin
      // Ascending scan: the highest-index matching port is assigned last.
      for (int i = 0; i < NWRITE; i++) begin
        if (i_we[i] && (i_waddr[i*AW +: AW] == i_raddr)) begin
          w_hit   = 1'b1;
          o_rdata = i_wdata[i*XLEN +: XLEN];
        end
      end
    end
    // A forwarded value is already available, so the reader need not stall.
    if (w_hit) begin
      o_rbusy = 1'b0;
    end
    if (ZERO_REG && (i_raddr == '0)) begin
      o_rdata = '0;
      o_rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/multiport_reg_file.sv
// ----------------------------------------------------------------------------
// multiport_reg_file
// Parametrised register file with NREAD combinational read ports, NWRITE
// write ports, same-cycle write-to-read bypass, optional hardwired zero
// register and a per-register pending scoreboard for pipeline stall logic.
//   clk, reset_n     : clock (rising edge), asynchronous active-low reset
//   we/waddr/wdata   : packed write ports, port i at [i*AW +: AW] etc.
//   raddr/rdata      : packed read ports
//   rbusy            : per read port, 1 = outstanding producer for raddr[j]
//   issue_valid/rd   : marks issue_rd pending at the next edge
//   pending_cnt      : registered count of pending registers
// ----------------------------------------------------------------------------
module multiport_reg_file
  import regfile_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEFAULT,
  parameter int  NREGS    = NREGS_DEFAULT,
  parameter int  NREAD    = 2,
  parameter int  NWRITE   = 2,
  parameter bit  ZERO_REG = 1'b1,
  parameter bit  BYPASS   = 1'b1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*XLEN-1:0]  wdata,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*XLEN-1:0]   rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_rd,
  output logic [AW:0]             pending_cnt
);

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [NREGS-1:0]           r_pending;
  logic [AW:0]                r_pending_cnt;

  logic [NWRITE-1:0]          w_wr_ok;
  logic [NREGS-1:0]           w_pending_next;
  logic [AW:0]                w_cnt_next;

  // Writes to the zero register are discarded when it is hardwired.
  always_comb begin
    for (int i = 0; i < NWRITE; i++) begin
      w_wr_ok[i] = we[i] && !(ZERO_REG && (waddr[i*AW +: AW] == '0));
    end
  end

  // Later ports in the loop override earlier ones on an address conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NWRITE; i++) begin
        if (w_wr_ok[i]) begin
          r_regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Writeback clears first, then issue sets, so a same-cycle issue wins.
  always_comb begin
    w_pending_next = r_pending;
    for (int i = 0; i < NWRITE; i++) begin
      if (we[i]) begin
        w_pending_next[waddr[i*AW +: AW]] = 1'b0;
      end
    end
    if (issue_valid) begin
      w_pending_next[issue_rd] = 1'b1;
    end
    if (ZERO_REG) begin
      w_pending_next[0] = 1'b0;
    end
    w_cnt_next = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_pending_next[r]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending     <= '0;
      r_pending_cnt <= '0;
    end else begin
      r_pending     <= w_pending_next;
      r_pending_cnt <= w_cnt_next;
    end
  end

  assign pending_cnt = r_pending_cnt;

  // Forwarding is suppressed in reset so every read port shows zero.
  for (genvar j = 0; j < NREAD; j++) begin : g_read
    reg_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .AW       (AW),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_read_port (
      .i_bypass_en (reset_n),
      .i_raddr     (raddr[j*AW +: AW]),
      .i_regs      (r_regs),
      .i_pending   (r_pending),
      .i_we        (we),
      .i_waddr     (waddr),
      .i_wdata     (wdata),
      .o_rdata     (rdata[j*XLEN +: XLEN]),
      .o_rbusy     (rbusy[j])
    );
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// ----------------------------------------------------------------------------
// tb_multiport_reg_file
// Directed and randomized checks of multiport_reg_file against a behavioural
// model (arrays of register values and pending flags).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 3 units after the edge and pending_cnt 1 unit after the edge.
// ----------------------------------------------------------------------------
module tb_multiport_reg_file;
  import regfile_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;

  logic                   clk;
  logic                   reset_n;
  logic [NWRITE-1:0]      we;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic                   issue_valid;
  logic [AW-1:0]          issue_rd;
  logic [AW:0]            pending_cnt;

  int n_checks;
  int n_errors;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_pend [NREGS];

  multiport_reg_file dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .pending_cnt (pending_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_update();
    logic [AW-1:0] a;
    for (int i = 0; i < NWRITE; i++) begin
      a = waddr[i*AW +: AW];
      if (we[i] && a != 0) m_regs[a] = wdata[i*XLEN +: XLEN];
    end
    for (int i = 0; i < NWRITE; i++) begin
      a = waddr[i*AW +: AW];
      if (we[i]) m_pend[a] = 1'b0;
    end
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
  endtask

  function automatic logic [31:0] model_cnt();
    logic [31:0] c;
    c = 0;
    for (int r = 0; r < NREGS; r++) c = c + {31'b0, m_pend[r]};
    return c;
  endfunction

  function automatic logic [31:0] exp_rdata(int j);
    logic [AW-1:0] a;
    logic [31:0]   v;
    a = raddr[j*AW +: AW];
    if (a == 0) return 32'h0;
    v = m_regs[a];
    for (int i = 0; i < NWRITE; i++) begin
      if (we[i] && waddr[i*AW +: AW] == a) v = wdata[i*XLEN +: XLEN];
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_rbusy(int j);
    logic [AW-1:0] a;
    a = raddr[j*AW +: AW];
    if (a == 0) return 32'h0;
    for (int i = 0; i < NWRITE; i++) begin
      if (we[i] && waddr[i*AW +: AW] == a) return 32'h0;
    end
    return {31'b0, m_pend[a]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(string tag);
    for (int j = 0; j < NREAD; j++) begin
      chk($sformatf("%s_rdata%0d", tag, j), rdata[j*XLEN +: XLEN], exp_rdata(j));
      chk($sformatf("%s_rbusy%0d", tag, j), {31'b0, rbusy[j]}, exp_rbusy(j));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic set_wr(int p, logic [AW-1:0] a, logic [XLEN-1:0] d);
    we[p]                = 1'b1;
    waddr[p*AW +: AW]    = a;
    wdata[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    raddr[p*AW +: AW] = a;
  endtask

  task automatic set_issue(logic [AW-1:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  // Clock edge: model follows the DUT, then pending_cnt is compared.
  task automatic step(string tag);
    @(posedge clk);
    model_update();
    #1;
    chk({tag, "_cnt"}, {26'b0, pending_cnt}, model_cnt());
  endtask

  task automatic randomize_inputs();
    we          = 2'($urandom_range(0, 3));
    waddr       = 10'($urandom_range(0, 1023));
    wdata       = {$urandom, $urandom};
    raddr       = 10'($urandom_range(0, 1023));
    issue_valid = 1'($urandom_range(0, 1));
    issue_rd    = 5'($urandom_range(0, 31));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_clear();
    reset_n = 1'b0;
    set_idle();
    raddr = '0;

    // Reset held with random activity on every input.
    for (int k = 0; k < 4; k++) begin
      randomize_inputs();
      #3;
      chk("rst_rdata0", rdata[31:0], 32'h0);
      chk("rst_rdata1", rdata[63:32], 32'h0);
      chk("rst_rbusy", {30'b0, rbusy}, 32'h0);
      chk("rst_cnt", {26'b0, pending_cnt}, 32'h0);
      #7;
    end
    set_idle();
    raddr   = '0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All addresses read zero after reset.
    for (int a = 0; a < NREGS; a += 2) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(a + 1));
      #2;
      chk($sformatf("post_rst_r%0d", a), rdata[31:0], 32'h0);
      chk($sformatf("post_rst_r%0d", a + 1), rdata[63:32], 32'h0);
      step("post_rst");
    end

    // Write with same-cycle bypass, then plain read.
    set_idle();
    set_wr(0, REG_T0, 32'hDEADBEEF);
    set_rd(0, REG_T0);
    set_rd(1, REG_ZERO);
    #2;
    chk("bypass_r5", rdata[31:0], 32'hDEADBEEF);
    check_ports("bypass");
    step("bypass");
    set_idle();
    #2;
    chk("stored_r5", rdata[31:0], 32'hDEADBEEF);
    check_ports("stored");
    step("stored");

    // Two ports writing the same register: port 1 wins.
    set_wr(0, 5'd7, 32'h11111111);
    set_wr(1, 5'd7, 32'h22222222);
    set_rd(1, 5'd7);
    #2;
    chk("conflict_bypass", rdata[63:32], 32'h22222222);
    check_ports("conflict");
    step("conflict");
    set_idle();
    set_rd(0, 5'd7);
    #2;
    chk("conflict_stored", rdata[31:0], 32'h22222222);
    step("conflict_rd");

    // Zero register ignores writes and issues.
    set_wr(0, REG_ZERO, 32'hFFFFFFFF);
    set_issue(REG_ZERO);
    set_rd(0, REG_ZERO);
    #2;
    chk("zero_rdata", rdata[31:0], 32'h0);
    chk("zero_rbusy", {31'b0, rbusy[0]}, 32'h0);
    step("zero");
    chk("zero_cnt", {26'b0, pending_cnt}, 32'h0);
    set_idle();
    #2;
    chk("zero_after", rdata[31:0], 32'h0);
    step("zero_after");

    // Scoreboard: issue, issue+write, write.
    set_issue(REG_A0);
    set_rd(0, REG_A0);
    #2;
    chk("sb_issue_old", {31'b0, rbusy[0]}, 32'h0);
    step("sb_issue");
    set_idle();
    #2;
    chk("sb_busy", {31'b0, rbusy[0]}, 32'h1);
    chk("sb_cnt1", {26'b0, pending_cnt}, 32'h1);
    set_issue(REG_A0);
    set_wr(0, REG_A0, 32'h0000A0A0);
    #2;
    chk("sb_both_fwd", {31'b0, rbusy[0]}, 32'h0);
    check_ports("sb_both");
    step("sb_both");
    set_idle();
    #2;
    chk("sb_still_busy", {31'b0, rbusy[0]}, 32'h1);
    chk("sb_still_cnt", {26'b0, pending_cnt}, 32'h1);
    set_wr(1, REG_A0, 32'h0000B0B0);
    #2;
    chk("sb_wb_fwd", {31'b0, rbusy[0]}, 32'h0);
    chk("sb_wb_data", rdata[31:0], 32'h0000B0B0);
    step("sb_wb");
    set_idle();
    #2;
    chk("sb_clear_cnt", {26'b0, pending_cnt}, 32'h0);
    chk("sb_clear_busy", {31'b0, rbusy[0]}, 32'h0);

    // Asynchronous reset in the middle of a cycle.
    set_issue(REG_HP);
    step("ar_i3");
    set_issue(REG_A0);
    step("ar_i10");
    set_issue(REG_T6);
    step("ar_i31");
    set_idle();
    set_rd(0, REG_A0);
    set_rd(1, REG_T6);
    #2;
    chk("ar_busy_before", {30'b0, rbusy}, 32'h3);
    chk("ar_cnt_before", {26'b0, pending_cnt}, 32'h3);
    chk("ar_data_before", rdata[31:0], 32'h0000B0B0);
    reset_n = 1'b0;
    #1;
    chk("ar_busy", {30'b0, rbusy}, 32'h0);
    chk("ar_cnt", {26'b0, pending_cnt}, 32'h0);
    chk("ar_data", rdata[31:0], 32'h0);
    model_clear();
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    set_rd(0, REG_T0);
    set_rd(1, 5'd7);
    #2;
    chk("ar_r5", rdata[31:0], 32'h0);
    chk("ar_r7", rdata[63:32], 32'h0);
    step("ar_done");

    // Randomized traffic with a narrow address range to provoke overlaps.
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] a0, a1;
      set_idle();
      a0 = 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) set_wr(0, a0, $urandom);
      if ($urandom_range(0, 1) == 1) set_wr(1, a1, $urandom);
      if ($urandom_range(0, 2) != 0) set_issue(($urandom_range(0, 1) == 1) ? a0 : 5'($urandom_range(0, 15)));
      set_rd(0, ($urandom_range(0, 1) == 1) ? a0 : 5'($urandom_range(0, 15)));
      set_rd(1, ($urandom_range(0, 1) == 1) ? a1 : 5'($urandom_range(0, 31)));
      #2;
      check_ports("rnd");
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
